// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ST_IDLE, ST_BURST} arb_state_e;

  localparam int DEF_MAX_BURST = 4;

  // A single producer still needs a 1-bit source ID.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  localparam logic [SRC_W:0]   NR      = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_ID = SRC_W'(NUM_REQ-1);

  logic [SRC_W:0]       start, off, sum_raw, sum;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotate so the highest-priority candidate lands in bit 0, then take the lowest set bit.
  always_comb begin
    start   = (last == LAST_ID) ? '0 : {1'b0, last} + (SRC_W+1)'(1);
    dbl     = {req, req} >> start;
    rot     = dbl[NUM_REQ-1:0];
    any     = |req;
    off     = '0;
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (rot[j]) off = (SRC_W+1)'(j);
    sum_raw = start + off;
    sum     = (sum_raw >= NR) ? sum_raw - NR : sum_raw;
    idx     = sum[SRC_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of the byte FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int SRC_W     = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [SRC_W-1:0]          fifo_wr_src,
  output logic                      grant_active,
  output logic [SRC_W-1:0]          grant_id
);

  localparam logic [3:0]       LAST_BEAT = 4'(MAX_BURST-1);
  localparam logic [SRC_W-1:0] LAST_ID   = SRC_W'(NUM_REQ-1);

  arb_state_e       state;
  logic [SRC_W-1:0] last_grant;
  logic [3:0]       burst_cnt;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic             sel_valid, in_burst, xfer;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id == SRC_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
  end

  // Gating with rst keeps an in-flight beat from being written while reset is asserted.
  assign in_burst = (state == ST_BURST) && !rst;
  assign xfer     = in_burst && sel_valid && !fifo_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (in_burst && !fifo_full && grant_id == SRC_W'(i)) req_ready[i] = 1'b1;
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = sel_data;
  assign fifo_wr_src  = grant_id;
  assign grant_active = in_burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= LAST_ID;
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_any) begin
          grant_id  <= pick_idx;
          burst_cnt <= '0;
          state     <= ST_BURST;
        end
        ST_BURST: begin
          if (xfer) burst_cnt <= burst_cnt + 4'd1;
          // Full-FIFO stalls neither count nor release; a dropped valid does release.
          if ((xfer && burst_cnt == LAST_BEAT) || !sel_valid) begin
            state      <= ST_IDLE;
            last_grant <= grant_id;
          end
        end
      endcase
    end
  end

endmodule
